// File: rtl/fwd_pkg.sv
// fwd_pkg: forward-select encodings, hazard FSM states and default address width
// shared by the forwarding/hazard unit and its per-operand comparator.
package fwd_pkg;
    localparam int REG_ADDR_W_DEF = 5;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    typedef enum logic {IDLE, STALL} state_e;
endpackage

// File: rtl/fwd_src_compare.sv
// fwd_src_compare: one source operand against the EX producer and the MEM shadow;
// yields the forward select and a raw EX-address hit used for load-use detection.
module fwd_src_compare
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_we_i,
    output logic [1:0]            sel_o,
    output logic                  hit_o
);
    logic nz;
    logic ex_hit;
    assign nz     = |rs_i;
    assign ex_hit = nz & (ex_rd_i == rs_i);
    assign hit_o  = ex_hit;
    // The EX producer is the newer one, so it takes priority over the MEM shadow.
    assign sel_o  = (id_valid_i & ex_we_i & ex_hit)          ? FWD_MEM :
                    (nz & mem_we_i & (mem_rd_i == rs_i))     ? FWD_WB  : FWD_NONE;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: registered operand forward selects plus counted load-use stall/bubble.
// Optional FWD_HAZARD_STATS_EN adds saturating stall-entry and forward counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int NUM_SRC      = 2,
    parameter int STALL_CYCLES = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          id_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic                          ex_valid_i,
    input  logic [REG_ADDR_W-1:0]         ex_rd_i,
    input  logic                          ex_reg_write_i,
    input  logic                          ex_mem_read_i,
    output logic [2*NUM_SRC-1:0]          fwd_sel_o,
    output logic                          stall_o,
    output logic                          bubble_o
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]                   stat_stalls_o,
    output logic [31:0]                   stat_fwds_o
`endif
);
    logic                  ex_we;
    logic [NUM_SRC-1:0]    hit;
    logic [2*NUM_SRC-1:0]  sel_d;
    logic [2*NUM_SRC-1:0]  fwd_sel_q;
    logic [REG_ADDR_W-1:0] mem_rd_q, wb_rd_q;
    logic                  mem_we_q, mem_ld_q, wb_we_q;
    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  hz, enter;
    logic                  unused;

    assign ex_we = ex_reg_write_i & ex_valid_i;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cmp
        fwd_src_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
            .id_valid_i (id_valid_i),
            .rs_i       (id_rs_addr_i[g*REG_ADDR_W +: REG_ADDR_W]),
            .ex_rd_i    (ex_rd_i),
            .ex_we_i    (ex_we),
            .mem_rd_i   (mem_rd_q),
            .mem_we_i   (mem_we_q),
            .sel_o      (sel_d[2*g +: 2]),
            .hit_o      (hit[g])
        );
    end

    // A hit already excludes x0, so a load into x0 can never stall.
    assign hz    = id_valid_i & ex_valid_i & ex_mem_read_i & (|hit);
    assign enter = (state_q == IDLE) & hz & ~flush_i;

    // cnt holds the stall cycles still owed, counting the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else if (state_q == STALL) begin
            stall_o = 1'b1;
            state_d = (cnt_q <= 2'd1) ? IDLE : STALL;
            cnt_d   = (cnt_q <= 2'd1) ? 2'd0 : cnt_q - 2'd1;
        end else if (hz) begin
            stall_o = 1'b1;
            state_d = (STALL_CYCLES > 1) ? STALL : IDLE;
            cnt_d   = (STALL_CYCLES > 1) ? 2'(STALL_CYCLES - 1) : 2'd0;
        end
    end

    assign bubble_o  = stall_o;
    assign fwd_sel_o = fwd_sel_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            fwd_sel_q <= '0;
            mem_rd_q  <= '0;
            mem_we_q  <= 1'b0;
            mem_ld_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            fwd_sel_q <= '0;
            mem_rd_q  <= '0;
            mem_we_q  <= 1'b0;
            mem_ld_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Hold on hazard entry so the select never points at the load's MEM stage.
            fwd_sel_q <= enter ? fwd_sel_q : sel_d;
            mem_rd_q  <= ex_rd_i;
            mem_we_q  <= ex_we;
            mem_ld_q  <= ex_mem_read_i & ex_valid_i;
            wb_rd_q   <= mem_rd_q;
            wb_we_q   <= mem_we_q;
        end
    end

    assign unused = ^{wb_rd_q, wb_we_q, mem_ld_q};

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stalls_q, stat_fwds_q;
    logic [1:0]  nfwd;
    logic [32:0] fsum;
    always_comb begin
        nfwd = '0;
        for (int i = 0; i < NUM_SRC; i++) nfwd = nfwd + 2'(|sel_d[2*i +: 2]);
    end
    assign fsum = {1'b0, stat_fwds_q} + 33'(nfwd);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_stalls_q <= '0;
            stat_fwds_q   <= '0;
        end else begin
            if (enter && !(&stat_stalls_q)) stat_stalls_q <= stat_stalls_q + 32'd1;
            if (!flush_i && !enter) stat_fwds_q <= fsum[32] ? '1 : fsum[31:0];
        end
    end
    assign stat_stalls_o = stat_stalls_q;
    assign stat_fwds_o   = stat_fwds_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: three instances (STALL_CYCLES 1..3) on shared stimulus, checked
// against a cycle-level reference model plus vector tables and directed corner cases.
module tb_fwd_hazard_unit;
    logic       clk = 1'b0;
    logic       rst_n, flush, id_valid, ex_valid, ex_wr, ex_ld;
    logic [9:0] id_rs;
    logic [4:0] ex_rd;
    logic [2:0] stall_w, bubble_w;
    logic [3:0] fwd_w [3];
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] sst [3];
    logic [31:0] sfw [3];
`endif
    int n_cmp = 0;
    int n_bad = 0;
    int m_rem [3];
    int m_fwd [3];
    int m_mem_rd, m_mem_we;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .STALL_CYCLES(g + 1)) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .flush_i        (flush),
            .id_valid_i     (id_valid),
            .id_rs_addr_i   (id_rs),
            .ex_valid_i     (ex_valid),
            .ex_rd_i        (ex_rd),
            .ex_reg_write_i (ex_wr),
            .ex_mem_read_i  (ex_ld),
            .fwd_sel_o      (fwd_w[g]),
            .stall_o        (stall_w[g]),
            .bubble_o       (bubble_w[g])
`ifdef FWD_HAZARD_STATS_EN
            ,
            .stat_stalls_o  (sst[g]),
            .stat_fwds_o    (sfw[g])
`endif
        );
    end

    typedef struct {
        logic       pre_we;
        logic [4:0] pre_rd;
        logic       idv;
        logic [4:0] rs1, rs2;
        logic       exv;
        logic [4:0] rd;
        logic       wr, ld;
        logic       exp_st;
        logic [3:0] exp_fwd;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0;
            m_fwd[k] = 0;
        end
        m_mem_rd = 0;
        m_mem_we = 0;
    endtask

    // One clock: stall/bubble checked mid-cycle, selects checked just after the edge.
    task automatic tick();
        int rs, any, hz, st, ent;
        int nsel [2];
        @(negedge clk);
        any = 0;
        for (int i = 0; i < 2; i++) begin
            rs = int'(id_rs[i*5 +: 5]);
            if (rs != 0 && rs == int'(ex_rd)) any = 1;
            nsel[i] = (id_valid && ex_valid && ex_wr && rs != 0 && rs == int'(ex_rd)) ? 1 :
                      (m_mem_we != 0 && rs != 0 && rs == m_mem_rd) ? 2 : 0;
        end
        hz = (id_valid && ex_valid && ex_ld && any != 0) ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            st  = (!flush && (m_rem[k] > 0 || hz != 0)) ? 1 : 0;
            ent = (!flush && m_rem[k] == 0 && hz != 0) ? 1 : 0;
            chk($sformatf("stall[sc%0d]", k + 1), int'(stall_w[k]), st);
            chk($sformatf("bubble[sc%0d]", k + 1), int'(bubble_w[k]), st);
            if (flush) m_fwd[k] = 0;
            else if (ent == 0) m_fwd[k] = nsel[1] * 4 + nsel[0];
            m_rem[k] = flush ? 0 : (m_rem[k] > 0) ? m_rem[k] - 1 : (ent != 0) ? k : 0;
        end
        m_mem_we = (!flush && ex_valid && ex_wr) ? 1 : 0;
        m_mem_rd = flush ? 0 : int'(ex_rd);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("fwd_sel[sc%0d]", k + 1), int'(fwd_w[k]), m_fwd[k]);
    endtask

    task automatic set_in(logic idv, logic [4:0] rs1, logic [4:0] rs2, logic exv,
                          logic [4:0] rd, logic wr, logic ld);
        id_valid = idv;
        id_rs    = {rs2, rs1};
        ex_valid = exv;
        ex_rd    = rd;
        ex_wr    = wr;
        ex_ld    = ld;
    endtask

    task automatic do_flush();
        set_in(0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 5'd0,  1, 5'd5,  5'd6,  1, 5'd5,  1, 0, 0, 4'b0001};
        tbl[1]  = '{1, 5'd7,  1, 5'd1,  5'd7,  1, 5'd9,  1, 0, 0, 4'b1000};
        tbl[2]  = '{1, 5'd7,  1, 5'd1,  5'd7,  1, 5'd7,  1, 0, 0, 4'b0100};
        tbl[3]  = '{1, 5'd0,  1, 5'd0,  5'd0,  1, 5'd0,  1, 1, 0, 4'b0000};
        tbl[4]  = '{0, 5'd0,  1, 5'd3,  5'd4,  1, 5'd3,  1, 1, 1, 4'b0000};
        tbl[5]  = '{0, 5'd0,  1, 5'd8,  5'd3,  1, 5'd3,  1, 1, 1, 4'b0000};
        tbl[6]  = '{0, 5'd0,  1, 5'd5,  5'd0,  0, 5'd5,  1, 0, 0, 4'b0000};
        tbl[7]  = '{1, 5'd12, 1, 5'd12, 5'd12, 1, 5'd1,  1, 0, 0, 4'b1010};
        tbl[8]  = '{0, 5'd0,  1, 5'd13, 5'd13, 1, 5'd13, 1, 0, 0, 4'b0101};
        tbl[9]  = '{1, 5'd5,  1, 5'd5,  5'd0,  1, 5'd5,  0, 0, 0, 4'b0010};
        tbl[10] = '{1, 5'd6,  0, 5'd5,  5'd6,  1, 5'd5,  1, 0, 0, 4'b1000};

        rst_n = 1'b0;
        flush = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("reset_fwd", int'(fwd_w[k]), 0);
            chk("reset_stall", int'(stall_w[k]), 0);
        end
        #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_flush();
            set_in(0, 0, 0, 1, tbl[i].pre_rd, tbl[i].pre_we, 0);
            tick();
            set_in(tbl[i].idv, tbl[i].rs1, tbl[i].rs2, tbl[i].exv, tbl[i].rd, tbl[i].wr, tbl[i].ld);
            #2 chk($sformatf("tbl%0d_stall", i), int'(stall_w[0]), int'(tbl[i].exp_st));
            tick();
            chk($sformatf("tbl%0d_fwd", i), int'(fwd_w[0]), int'(tbl[i].exp_fwd));
        end

        // Load-use release for each stall length: stall held exactly STALL_CYCLES cycles.
        for (int k = 0; k < 3; k++) begin
            do_flush();
            set_in(1, 5'd3, 5'd0, 1, 5'd3, 1, 1);
            #2 chk("ld_use_stall", int'(stall_w[k]), 1);
            tick();
            for (int j = 0; j < k; j++) begin
                set_in(1, 5'd3, 5'd0, 0, 5'd0, 0, 0);
                #2 chk("ld_use_hold", int'(stall_w[k]), 1);
                tick();
            end
            set_in(1, 5'd3, 5'd0, 0, 5'd0, 0, 0);
            #2 chk("ld_use_release", int'(stall_w[k]), 0);
            tick();
            chk("ld_use_fwd", int'(fwd_w[k][1:0]), (k == 0) ? 2 : 0);
        end

        do_flush();
        set_in(1, 5'd3, 5'd0, 1, 5'd3, 1, 1);
        #2 chk("flush_stall_entry", int'(stall_w[2]), 1);
        tick();
        set_in(1, 5'd3, 5'd0, 0, 5'd0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_fwd", int'(fwd_w[2]), 0);
        #2 chk("flush_stall_after", int'(stall_w[2]), 0);
        tick();

        do_flush();
        set_in(1, 5'd3, 5'd0, 1, 5'd3, 1, 1);
        tick();
        set_in(1, 5'd3, 5'd0, 0, 5'd0, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("areset_stall", int'(stall_w[k]), 0);
            chk("areset_bubble", int'(bubble_w[k]), 0);
            chk("areset_fwd", int'(fwd_w[k]), 0);
`ifdef FWD_HAZARD_STATS_EN
            chk("areset_stat_stalls", int'(sst[k]), 0);
`endif
        end
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        tick();

        for (int c = 0; c < 600; c++) begin
            flush    = ($urandom_range(0, 15) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_rd    = 5'($urandom_range(0, 7));
            ex_wr    = ($urandom_range(0, 1) == 1);
            ex_ld    = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
